conv_mac_9: RTL and testbench

CONV_MAC_9 -- requirements
Module: conv_mac_9

---
 rtl/conv_mac_9.sv | 98 +++++++++
 tb/tb_conv_mac_9.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_9.sv
// Streaming multiply-accumulate: consumes KERN_S weight/activation pairs from two
// FIFOs, then emits one shifted and saturated result to the downstream FIFO.
module conv_mac_9 #(
  parameter int KERN_S  = 9,
  parameter int COEFF_W = 16,
  parameter int ACT_W   = 16,
  parameter int ACC_W   = 40,
  parameter int SHIFT   = 8,
  parameter int OUT_W   = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [COEFF_W-1:0] weight_V_dout,
  input  logic               weight_V_empty_n,
  output logic               weight_V_read,
  input  logic [ACT_W-1:0]   act_V_dout,
  input  logic               act_V_empty_n,
  output logic               act_V_read,
  output logic [OUT_W-1:0]   output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write
);

  localparam int PROD_W = COEFF_W + ACT_W;
  localparam int CNT_W  = (KERN_S > 1) ? $clog2(KERN_S) : 1;

  typedef enum logic {ST_ACC, ST_EMIT} state_t;

  state_t                   state_q, state_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0] prod;
  logic                     pair_ok;

  // Floor shift, then clamp by checking that all bits above the output sign agree.
  function automatic logic signed [OUT_W-1:0] shift_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
    if ((&s[ACC_W-1:OUT_W-1]) || !(|s[ACC_W-1:OUT_W-1]))
      return s[OUT_W-1:0];
    else if (s[ACC_W-1])
      return {1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  assign prod    = $signed(weight_V_dout) * $signed(act_V_dout);
  assign pair_ok = weight_V_empty_n & act_V_empty_n;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    weight_V_read  = 1'b0;
    act_V_read     = 1'b0;
    output_V_write = 1'b0;
    case (state_q)
      ST_ACC: begin
        // Reads are gated by reset so nothing is popped while the block is held.
        weight_V_read = pair_ok & ap_rst_n;
        act_V_read    = pair_ok & ap_rst_n;
        if (pair_ok) begin
          acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
          if (cnt_q == CNT_W'(KERN_S-1)) begin
            cnt_d   = '0;
            state_d = ST_EMIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_EMIT: begin
        output_V_write = output_V_full_n;
        if (output_V_full_n) begin
          acc_d   = '0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // acc is frozen in EMIT, so the result stays stable while the sink stalls.
  assign output_V_din = shift_sat(acc_q);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_conv_mac_9.sv
// Scoreboard bench for conv_mac_9: a FIFO-style driver feeds pairs, a behavioural
// model queues expected results, and a negedge monitor checks protocol and data.
module tb_conv_mac_9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] weight_V_dout, act_V_dout, output_V_din;
  logic        weight_V_empty_n, act_V_empty_n, output_V_full_n;
  logic        weight_V_read, act_V_read, output_V_write;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          rd_cyc  = 0;
  int          wr_cyc  = 0;
  int          wr_count = 0;
  int          n_push  = 0;
  longint      exp_q[$];
  int          wv[9];
  int          av[9];

  conv_mac_9 dut (
    .ap_clk           (clk),
    .ap_rst_n         (rst_n),
    .weight_V_dout    (weight_V_dout),
    .weight_V_empty_n (weight_V_empty_n),
    .weight_V_read    (weight_V_read),
    .act_V_dout       (act_V_dout),
    .act_V_empty_n    (act_V_empty_n),
    .act_V_read       (act_V_read),
    .output_V_din     (output_V_din),
    .output_V_full_n  (output_V_full_n),
    .output_V_write   (output_V_write)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic longint model();
    longint s = 0;
    for (int k = 0; k < 9; k++) s += longint'(wv[k]) * longint'(av[k]);
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_pair", weight_V_read, act_V_read);
      if (weight_V_read) begin
        check("rd_when_empty", weight_V_empty_n & act_V_empty_n, 1);
        rd_cyc = cyc;
      end
      if (output_V_write) begin
        check("wr_when_full", output_V_full_n, 1);
        wr_cyc = cyc;
        wr_count++;
        if (exp_q.size() == 0) check("unexpected_wr", 1, 0);
        else check("din", $signed(output_V_din), exp_q.pop_front());
      end
    end
  end

  task automatic feed(input int n, input bit push, input bit tog);
    bit ph = 1'b0;
    bit got;
    int guard;
    if (push) begin
      exp_q.push_back(model());
      n_push++;
    end
    for (int k = 0; k < n; k++) begin
      weight_V_dout = 16'(wv[k]);
      act_V_dout    = 16'(av[k]);
      guard = 0;
      forever begin
        weight_V_empty_n = tog ? ph : 1'b1;
        act_V_empty_n    = 1'b1;
        ph = ~ph;
        @(negedge clk);
        got = weight_V_read & weight_V_empty_n;
        @(posedge clk); #1;
        if (got) break;
        guard++;
        if (guard > 200) begin
          check("feed_timeout", guard, 0);
          return;
        end
      end
    end
    weight_V_empty_n = 1'b0;
    act_V_empty_n    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 9; k++) begin
      wv[k] = 256;
      av[k] = k + 1;
    end
  endtask

  initial begin
    logic [15:0] held;
    int          wr0;
    rst_n            = 1'b0;
    weight_V_dout    = 16'h1234;
    act_V_dout       = 16'h0101;
    weight_V_empty_n = 1'b1;
    act_V_empty_n    = 1'b1;
    output_V_full_n  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wread", weight_V_read, 0);
    check("rst_aread", act_V_read, 0);
    check("rst_write", output_V_write, 0);
    check("rst_din", output_V_din, 0);
    weight_V_empty_n = 1'b0;
    act_V_empty_n    = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp, no stalls: write lands on the cycle right after the last read.
    set_ramp();
    feed(9, 1'b1, 1'b0);
    check("ramp_model", model(), 45);
    drain();
    check("latency", wr_cyc - rd_cyc, 1);

    // Positive and negative saturation.
    for (int k = 0; k < 9; k++) begin wv[k] = 32767; av[k] = 32767; end
    feed(9, 1'b1, 1'b0);
    drain();
    for (int k = 0; k < 9; k++) begin wv[k] = -32768; av[k] = 32767; end
    feed(9, 1'b1, 1'b0);
    drain();

    // Floor shift of a small negative sum.
    for (int k = 0; k < 9; k++) begin wv[k] = 1; av[k] = 0; end
    av[0] = -1;
    feed(9, 1'b1, 1'b0);
    drain();

    // Downstream stall while a result is pending.
    set_ramp();
    output_V_full_n = 1'b0;
    feed(9, 1'b1, 1'b0);
    held = output_V_din;
    wr0  = wr_count;
    repeat (5) begin
      @(negedge clk);
      check("stall_write", output_V_write, 0);
      check("stall_read", weight_V_read | act_V_read, 0);
      check("stall_din", output_V_din, held);
    end
    @(posedge clk); #1;
    output_V_full_n = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("stall_one_write", wr_count - wr0, 1);

    // Upstream stall: weight_V_empty_n toggles every cycle.
    set_ramp();
    feed(9, 1'b1, 1'b1);
    drain();

    // Random data with toggled stalls.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 9; k++) begin
        wv[k] = int'($urandom_range(0, 65535)) - 32768;
        av[k] = int'($urandom_range(0, 4095)) - 2048;
      end
      feed(9, 1'b1, r[0]);
      drain();
    end

    // Reset mid-accumulation discards the partial result.
    set_ramp();
    feed(4, 1'b0, 1'b0);
    weight_V_empty_n = 1'b1;
    act_V_empty_n    = 1'b1;
    rst_n = 1'b0;
    #2;
    check("mid_rst_din", output_V_din, 0);
    check("mid_rst_read", weight_V_read | act_V_read, 0);
    check("mid_rst_write", output_V_write, 0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_din2", output_V_din, 0);
    weight_V_empty_n = 1'b0;
    act_V_empty_n    = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    feed(9, 1'b1, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    #1;
    check("write_count", wr_count, n_push);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
